control_sequencer: RTL and testbench

Microcoded control sequencer for the NSC-8 CPU, directly downstream of the instruction register. It consumes the opcode nibble the instruction register presents to the controller. A 5-step T-state counter and a decode of (opcode, step, flags) drive every load, output-enable and count strobe in the datapath, including the instruction register's own `load_ir` and `output_enable_ir`.

---
 rtl/nsc8_ctrl_pkg.sv | 68 ++++++
 rtl/control_sequencer_if.sv | 24 ++
 rtl/step_counter.sv | 32 +++
 rtl/control_sequencer.sv | 85 ++++++++
 tb/tb_control_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nsc8_ctrl_pkg.sv
// Shared constants for the NSC-8 control sequencer: control-word bit
// indices, opcode encodings, T-state encodings and prebuilt control words.
package nsc8_ctrl_pkg;

  localparam int CTRL_W = 16;

  // Control word bit indices
  localparam int CTRL_HLT      = 15;
  localparam int CTRL_MAR_IN   = 14;
  localparam int CTRL_RAM_IN   = 13;
  localparam int CTRL_RAM_OUT  = 12;
  localparam int CTRL_IR_OUT   = 11;
  localparam int CTRL_IR_IN    = 10;
  localparam int CTRL_A_IN     = 9;
  localparam int CTRL_A_OUT    = 8;
  localparam int CTRL_ALU_OUT  = 7;
  localparam int CTRL_SUB      = 6;
  localparam int CTRL_B_IN     = 5;
  localparam int CTRL_OUT_IN   = 4;
  localparam int CTRL_PC_EN    = 3;
  localparam int CTRL_PC_OUT   = 2;
  localparam int CTRL_JUMP     = 1;
  localparam int CTRL_FLAGS_IN = 0;

  // Opcode encodings (upper nibble of the instruction register)
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // T-state encodings
  localparam int STEP_COUNT = 5;
  localparam int STEP_W     = 3;
  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  // One-hot helper for building control words from bit indices
  function automatic logic [CTRL_W-1:0] cbit(input int idx);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  localparam logic [CTRL_W-1:0] C_FETCH0 = cbit(CTRL_PC_OUT) | cbit(CTRL_MAR_IN);
  localparam logic [CTRL_W-1:0] C_FETCH1 = cbit(CTRL_RAM_OUT) | cbit(CTRL_IR_IN) | cbit(CTRL_PC_EN);
  localparam logic [CTRL_W-1:0] C_ADDR   = cbit(CTRL_IR_OUT) | cbit(CTRL_MAR_IN);
  localparam logic [CTRL_W-1:0] C_LDA3   = cbit(CTRL_RAM_OUT) | cbit(CTRL_A_IN);
  localparam logic [CTRL_W-1:0] C_LDB3   = cbit(CTRL_RAM_OUT) | cbit(CTRL_B_IN);
  localparam logic [CTRL_W-1:0] C_ALU4   = cbit(CTRL_ALU_OUT) | cbit(CTRL_A_IN) | cbit(CTRL_FLAGS_IN);
  localparam logic [CTRL_W-1:0] C_STA3   = cbit(CTRL_A_OUT) | cbit(CTRL_RAM_IN);
  localparam logic [CTRL_W-1:0] C_LDI2   = cbit(CTRL_IR_OUT) | cbit(CTRL_A_IN);
  localparam logic [CTRL_W-1:0] C_JMP2   = cbit(CTRL_IR_OUT) | cbit(CTRL_JUMP);
  localparam logic [CTRL_W-1:0] C_OUT2   = cbit(CTRL_A_OUT) | cbit(CTRL_OUT_IN);
  localparam logic [CTRL_W-1:0] C_HLT    = cbit(CTRL_HLT);

endpackage

// File: rtl/control_sequencer_if.sv
// Controller-facing bundle: opcode and flags in, control word and
// T-state/halt status out. There is no valid/ready handshake: the opcode
// is qualified purely by the T-state (meaningful only in T2..T4) and the
// control word is valid combinationally for the whole of each step.
interface control_sequencer_if #(parameter int N = 8);
  logic [N/2-1:0] opcode;
  logic           carry_flag;
  logic           zero_flag;
  logic [15:0]    ctrl;
  logic [2:0]     step;
  logic           halted;

  // Datapath side: presents opcode/flags, consumes strobes
  modport master (
    output opcode, carry_flag, zero_flag,
    input  ctrl, step, halted
  );

  // Sequencer side
  modport slave (
    input  opcode, carry_flag, zero_flag,
    output ctrl, step, halted
  );
endinterface

// File: rtl/step_counter.sv
// Mod-5 T-state counter (0..4) with async active-low clear and a hold
// input that freezes the count while the CPU is halting/halted.
module step_counter
  import nsc8_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clear_n,
  input  logic              hold,
  output logic [STEP_W-1:0] step_o
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  // Next step: hold, wrap after T4, otherwise increment
  always_comb begin
    step_d = step_q;
    if (!hold) begin
      if (step_q == T4) step_d = T0;
      else              step_d = step_q + 3'd1;
    end
  end

  // Step register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) step_q <= T0;
    else          step_q <= step_d;
  end

  assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// NSC-8 microcoded control sequencer: decodes (opcode, T-state, flags)
// into the 16-bit datapath control word and latches HLT.
// Optional feature macro: NSC8_COND_JUMP_EN enables JC/JZ; when undefined
// those opcodes decode as NOP and the flag inputs are ignored.
module control_sequencer
  import nsc8_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                clear_n,
  control_sequencer_if.slave  bus
);

  logic [STEP_W-1:0] step_w;
  logic              halted_q;
  logic              halted_d;
  logic              halt_fire;
  logic [CTRL_W-1:0] ctrl_w;

  // HLT takes effect on the edge that ends its T2; from then on the step
  // counter is frozen at T2 until clear_n.
  assign halt_fire = (step_w == T2) && (bus.opcode == OP_HLT) && !halted_q;
  assign halted_d  = halted_q | halt_fire;

  step_counter u_step (
    .clk     (clk),
    .clear_n (clear_n),
    .hold    (halt_fire | halted_q),
    .step_o  (step_w)
  );

  // Halt latch
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) halted_q <= 1'b0;
    else          halted_q <= halted_d;
  end

`ifndef NSC8_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = bus.carry_flag ^ bus.zero_flag;
`endif

  // Microcode decode; fetch steps ignore the opcode entirely
  always_comb begin
    ctrl_w = '0;
    if (halted_q) begin
      ctrl_w = C_HLT;
    end else begin
      case (step_w)
        T0: ctrl_w = C_FETCH0;
        T1: ctrl_w = C_FETCH1;
        default: begin
          case (bus.opcode)
            OP_LDA: begin
              if (step_w == T2) ctrl_w = C_ADDR;
              if (step_w == T3) ctrl_w = C_LDA3;
            end
            OP_ADD, OP_SUB: begin
              if (step_w == T2) ctrl_w = C_ADDR;
              if (step_w == T3) ctrl_w = C_LDB3;
              if (step_w == T4) ctrl_w = C_ALU4 | ((bus.opcode == OP_SUB) ? cbit(CTRL_SUB) : '0);
            end
            OP_STA: begin
              if (step_w == T2) ctrl_w = C_ADDR;
              if (step_w == T3) ctrl_w = C_STA3;
            end
            OP_LDI: if (step_w == T2) ctrl_w = C_LDI2;
            OP_JMP: if (step_w == T2) ctrl_w = C_JMP2;
`ifdef NSC8_COND_JUMP_EN
            OP_JC: if (step_w == T2) ctrl_w = bus.carry_flag ? C_JMP2 : cbit(CTRL_IR_OUT);
            OP_JZ: if (step_w == T2) ctrl_w = bus.zero_flag  ? C_JMP2 : cbit(CTRL_IR_OUT);
`endif
            OP_OUT: if (step_w == T2) ctrl_w = C_OUT2;
            OP_HLT: if (step_w == T2) ctrl_w = C_HLT;
            default: ctrl_w = '0;
          endcase
        end
      endcase
    end
  end

  assign bus.ctrl   = ctrl_w;
  assign bus.step   = step_w;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: expected control words come from a
// table-driven model of the microcode and are checked through a queue.
module tb_control_sequencer;
  import nsc8_ctrl_pkg::*;

  logic clk = 1'b0;
  logic clear_n;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] exp_q[$];
  logic [2:0]  exp_step_q[$];

  control_sequencer_if #(.N(8)) bus ();

  control_sequencer dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference microcode table
  function automatic logic [15:0] model_ctrl(input logic [3:0] op, input int s,
                                             input logic c, input logic z);
    if (s == 0) return 16'h4004;
    if (s == 1) return 16'h1408;
    case (op)
      4'h1: return (s == 2) ? 16'h4800 : (s == 3) ? 16'h1200 : 16'h0000;
      4'h2: return (s == 2) ? 16'h4800 : (s == 3) ? 16'h1020 : 16'h0281;
      4'h3: return (s == 2) ? 16'h4800 : (s == 3) ? 16'h1020 : 16'h02C1;
      4'h4: return (s == 2) ? 16'h4800 : (s == 3) ? 16'h2100 : 16'h0000;
      4'h5: return (s == 2) ? 16'h0A00 : 16'h0000;
      4'h6: return (s == 2) ? 16'h0802 : 16'h0000;
`ifdef NSC8_COND_JUMP_EN
      4'h7: return (s == 2) ? (c ? 16'h0802 : 16'h0800) : 16'h0000;
      4'h8: return (s == 2) ? (z ? 16'h0802 : 16'h0800) : 16'h0000;
`endif
      4'hE: return (s == 2) ? 16'h0110 : 16'h0000;
      4'hF: return (s == 2) ? 16'h8000 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // Driver: runs steps first..last of one instruction starting #1 after a
  // rising edge; expectations are queued up front and popped per cycle.
  task automatic run_steps(input string name, input logic [3:0] op, input logic c,
                           input logic z, input int first, input int last);
    logic [15:0] exp_c;
    logic [2:0]  exp_s;
    for (int s = first; s <= last; s++) begin
      exp_q.push_back(model_ctrl(op, s, c, z));
      exp_step_q.push_back(3'(s));
    end
    for (int s = first; s <= last; s++) begin
      bus.opcode     = (s < 2) ? 4'($urandom_range(0, 15)) : op;
      bus.carry_flag = c;
      bus.zero_flag  = z;
      @(negedge clk);
      exp_c = exp_q.pop_front();
      exp_s = exp_step_q.pop_front();
      checks++;
      if (bus.ctrl !== exp_c) begin
        errors++;
        $display("FAIL %s ctrl T%0d: got %h expected %h", name, s, bus.ctrl, exp_c);
      end
      checks++;
      if (bus.step !== exp_s) begin
        errors++;
        $display("FAIL %s step: got %0d expected %0d", name, bus.step, exp_s);
      end
      checks++;
      if (bus.halted !== 1'b0) begin
        errors++;
        $display("FAIL %s halted T%0d: got %b expected 0", name, s, bus.halted);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    clear_n        = 1'b0;
    bus.opcode     = 4'h0;
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.step !== 3'd0) begin errors++; $display("FAIL reset step: got %0d expected 0", bus.step); end
    checks++;
    if (bus.ctrl !== 16'h4004) begin errors++; $display("FAIL reset ctrl: got %h expected 4004", bus.ctrl); end
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset halted: got %b expected 0", bus.halted); end
    clear_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    run_steps("rst_mid_pre", OP_ADD, 1'b0, 1'b0, 0, 2);
    // now inside T3
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (bus.step !== 3'd0) begin errors++; $display("FAIL rst_mid step: got %0d expected 0", bus.step); end
    checks++;
    if (bus.ctrl !== 16'h4004) begin errors++; $display("FAIL rst_mid ctrl: got %h expected 4004", bus.ctrl); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.step !== 3'd0) begin errors++; $display("FAIL rst_hold step: got %0d expected 0", bus.step); end
    clear_n = 1'b1;
    checks++;
    if (bus.ctrl !== 16'h4004) begin errors++; $display("FAIL rst_rel ctrl: got %h expected 4004", bus.ctrl); end
    @(posedge clk);
    #1;
    run_steps("rst_mid_post", OP_ADD, 1'b0, 1'b0, 1, 4);
  endtask

  task automatic test_alu_and_load();
    run_steps("add", OP_ADD, 1'b0, 1'b0, 0, 4);
    run_steps("sub", OP_SUB, 1'b1, 1'b1, 0, 4);
    run_steps("lda", OP_LDA, 1'b0, 1'b1, 0, 4);
    run_steps("ldi", OP_LDI, 1'b1, 1'b0, 0, 4);
    run_steps("jmp", OP_JMP, 1'b0, 1'b0, 0, 4);
  endtask

  task automatic test_cond_jump();
    logic [15:0] e;
    run_steps("jc_c1", OP_JC, 1'b1, 1'b0, 0, 4);
    run_steps("jc_c0", OP_JC, 1'b0, 1'b1, 0, 4);
    run_steps("jz_z1", OP_JZ, 1'b0, 1'b1, 0, 4);
    run_steps("jz_z0", OP_JZ, 1'b1, 1'b0, 0, 4);
    // carry drops in the middle of T2
    run_steps("jc_mid", OP_JC, 1'b1, 1'b0, 0, 1);
    bus.opcode     = OP_JC;
    bus.carry_flag = 1'b1;
    #2;
    e = model_ctrl(OP_JC, 2, 1'b1, 1'b0);
    checks++;
    if (bus.ctrl !== e) begin errors++; $display("FAIL jc_mid carry1: got %h expected %h", bus.ctrl, e); end
    bus.carry_flag = 1'b0;
    #1;
    e = model_ctrl(OP_JC, 2, 1'b0, 1'b0);
    checks++;
    if (bus.ctrl !== e) begin errors++; $display("FAIL jc_mid carry0: got %h expected %h", bus.ctrl, e); end
    @(posedge clk);
    #1;
    run_steps("jc_mid_tail", OP_JC, 1'b0, 1'b0, 3, 4);
  endtask

  task automatic test_nops();
    for (int op = 9; op <= 13; op++) begin
      run_steps("nop_hi", 4'(op), 4'(op) != 4'd10, 4'(op) == 4'd10, 0, 4);
    end
    run_steps("nop_0", OP_NOP, 1'b1, 1'b1, 0, 4);
  endtask

  task automatic test_back_to_back();
    run_steps("b2b_sta", OP_STA, 1'b0, 1'b0, 0, 4);
    run_steps("b2b_out", OP_OUT, 1'b0, 1'b0, 0, 4);
    run_steps("b2b_next", OP_LDI, 1'b0, 1'b0, 0, 4);
  endtask

  task automatic test_halt();
    run_steps("hlt", OP_HLT, 1'b0, 1'b0, 0, 2);
    checks++;
    if (bus.halted !== 1'b1) begin errors++; $display("FAIL hlt halted: got %b expected 1", bus.halted); end
    for (int i = 0; i < 10; i++) begin
      bus.opcode     = 4'($urandom_range(0, 15));
      bus.carry_flag = 1'($urandom_range(0, 1));
      bus.zero_flag  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.step !== 3'd2) begin errors++; $display("FAIL hlt_hold step: got %0d expected 2", bus.step); end
      checks++;
      if (bus.ctrl !== 16'h8000) begin errors++; $display("FAIL hlt_hold ctrl: got %h expected 8000", bus.ctrl); end
      checks++;
      if (bus.halted !== 1'b1) begin errors++; $display("FAIL hlt_hold halted: got %b expected 1", bus.halted); end
      @(posedge clk);
      #1;
    end
    clear_n = 1'b0;
    #1;
    checks++;
    if (bus.ctrl !== 16'h4004) begin errors++; $display("FAIL hlt_clr ctrl: got %h expected 4004", bus.ctrl); end
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL hlt_clr halted: got %b expected 0", bus.halted); end
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    run_steps("post_hlt", OP_ADD, 1'b0, 1'b0, 0, 4);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_alu_and_load();
    test_cond_jump();
    test_nops();
    test_back_to_back();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
